// File: rtl/fpadd_sequencer.sv
`timescale 1ns/1ps
// Sequencer for the FP adder demo: walks the operand ROM, issues each pair to the
// pipelined adder, captures the sum after the adder latency and holds it for display.
module fpadd_sequencer #(
  parameter int unsigned NUM     = 10,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned LAT     = 3,
  parameter int unsigned DWELL   = 50000000,
  parameter int unsigned DWELL_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_a,
  input  logic [31:0]       rom_b,
  output logic [31:0]       op_a,
  output logic [31:0]       op_b,
  output logic              op_valid,
  input  logic [31:0]       res_in,
  output logic [31:0]       result,
  output logic              result_valid,
  output logic [ADDR_W-1:0] entry_idx,
  output logic              pass_done,
  output logic              busy
);

  localparam int unsigned LAT_W = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT,
    DWELL_ST,
    ADVANCE
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [ADDR_W-1:0]  next_idx;

  always_comb begin
    next_idx = entry_idx + ADDR_W'(1);
    if (entry_idx == ADDR_W'(NUM - 1)) next_idx = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rom_addr     <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_valid     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      entry_idx    <= '0;
      pass_done    <= 1'b0;
      busy         <= 1'b0;
      lat_cnt      <= '0;
      dwell_cnt    <= '0;
    end else begin
      op_valid  <= 1'b0;
      pass_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        // The ROM address already points at this entry, so its data is
        // valid now and the operands are registered to line up with op_valid.
        FETCH: begin
          state    <= ISSUE;
          op_a     <= rom_a;
          op_b     <= rom_b;
          op_valid <= 1'b1;
          lat_cnt  <= '0;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(LAT - 1)) begin
            result       <= res_in;
            result_valid <= 1'b1;
            dwell_cnt    <= '0;
            state        <= DWELL_ST;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        DWELL_ST: begin
          if (dwell_cnt == DWELL_W'(DWELL - 1)) begin
            state     <= ADVANCE;
            // Present the next address a cycle early to hide the ROM read latency.
            rom_addr  <= next_idx;
            pass_done <= (entry_idx == ADDR_W'(NUM - 1));
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
        ADVANCE: begin
          entry_idx <= next_idx;
          busy      <= run;
          state     <= run ? FETCH : IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fpadd_sequencer.md
Name: fpadd_sequencer

Overview:
- Controller that drives the pipelined FP adder in the FP adder system.
- Walks the operand ROM entry by entry and issues each operand pair to the adder.
- Waits out the adder's fixed pipeline latency, then captures the sum.
- Holds the sum for a dwell period so the LED and seven-segment display logic can show it, then advances, wrapping after the last entry.

Parameters:
- NUM, 10, number of ROM entries (operand pairs); must be ≥1.
- ADDR_W, 4, ROM address / entry index width; 2^ADDR_W ≥ NUM.
- LAT, 3, adder latency in cycles from op_valid cycle to result at res_in; must be ≥1.
- DWELL, 50000000, cycles each captured result is held before advancing; must be ≥1.
- DWELL_W, 26, dwell counter width; 2^DWELL_W > DWELL.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- run  in  1  level; 1 = sequence continuously, 0 = stop after current entry.
- rom_addr  out  ADDR_W  operand ROM address; ROM has synchronous read, 1-cycle latency.
- rom_a  in  32  operand A from ROM, valid the cycle after rom_addr is presented.
- rom_b  in  32  operand B from ROM, same timing as rom_a.
- op_a  out  32  registered operand A to adder.
- op_b  out  32  registered operand B to adder.
- op_valid  out  1  one-cycle issue strobe to adder.
- res_in  in  32  adder sum; valid LAT cycles after the op_valid cycle.
- result  out  32  last captured sum, held between captures.
- result_valid  out  1  1 from first capture until reset.
- entry_idx  out  ADDR_W  index of the entry currently in flight or displayed.
- pass_done  out  1  one-cycle pulse when entry NUM-1 completes.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - State goes to IDLE.
  - rom_addr, op_a, op_b, result, entry_idx and both counters clear to 0.
  - op_valid, result_valid, pass_done and busy clear to 0.
- FSM states, one transition per clk:
  - IDLE: if run=1, go to FETCH; otherwise stay.
  - FETCH: rom_addr=entry_idx; 1 cycle, then ISSUE.
  - ISSUE: op_a/op_b <= rom_a/rom_b; op_valid=1 during this cycle only; latency counter cleared; next WAIT.
  - WAIT: exactly LAT cycles. At the edge ending the LAT-th WAIT cycle, result<=res_in and result_valid<=1; next DWELL.
  - DWELL: exactly DWELL cycles with result held; next ADVANCE.
  - ADVANCE: 1 cycle. entry_idx <= (entry_idx==NUM-1) ? 0 : entry_idx+1. pass_done=1 this cycle iff the old entry_idx==NUM-1. Next FETCH if run=1, else IDLE.
- Timing:
  - Entry period = LAT+DWELL+3 cycles.
  - If run rises in IDLE cycle 0: FETCH is cycle 1, op_valid is cycle 2, capture is visible from cycle 3+LAT.
- op_a/op_b hold their last issued value outside ISSUE.
- run sampling:
  - run is sampled only in IDLE and ADVANCE.
  - Dropping run mid-entry never aborts it: the entry completes, then the FSM parks in IDLE.
  - In IDLE, result and entry_idx (already advanced) are held.
- NUM=1: entry_idx stays 0; pass_done pulses every entry.
- Wrap-around: the sequence restarts at index 0 with no extra idle cycle.
- res_in is ignored outside the capture edge; no adder backpressure exists.
- Reset mid-operation:
  - Any in-flight issue is abandoned.
  - After release, the FSM restarts from entry 0 in IDLE.

Test Plan (LAT=3, DWELL=4, NUM=3, adder model = 3-stage delay of the true FP sum):
- Hold rst=0 with run=1 for 5 cycles -> all outputs 0, busy=0, op_valid never pulses; after release, busy rises the first edge run=1 is seen.
- ROM[0]=3F800000/40000000, run rises in cycle 0:
  - rom_addr=0 in cycle 1.
  - op_valid=1 only in cycle 2, with op_a=3F800000 and op_b=40000000.
  - result=40400000 and result_valid=1 from cycle 6.
  - ADVANCE in cycle 10; FETCH of entry 1 in cycle 11.
- ROM[1]=40400000/3F800000 (sum 40800000), ROM[2]=C0000000/40000000 (sum 00000000), run held 1:
  - results 40400000, 40800000, 00000000, then 40400000 again.
  - entry_idx sequence 0,1,2,0.
  - pass_done is high exactly in cycle 30 and nowhere else in 0..39.
- Drop run during the WAIT of entry 1:
  - result becomes 40800000, then busy=0 after ADVANCE.
  - entry_idx=2 held; no further op_valid.
  - Re-raising run issues ROM[2] two cycles later.
- Assert rst=0 asynchronously between edges mid-DWELL -> result, result_valid, entry_idx and busy go 0 before the next clk edge; after release with run=1, rom_addr=0 is fetched first.
